// File: rtl/noc_pe_interface_pkg.sv
// Shared NoC definitions: flit field offsets, flit packing and RX error flag layout.
// The flit is {dest_y, dest_x, payload}, with the payload in the LSBs.
package noc_pe_interface_pkg;

  // Widest flit the pack helper handles; callers size-cast into and out of it.
  localparam int unsigned FLIT_MAX_W = 1024;

  typedef struct packed {
    logic overflow;
    logic misroute;
  } rx_err_t;

  function automatic int unsigned flit_x_lsb(input int unsigned dw);
    return dw;
  endfunction

  function automatic int unsigned flit_y_lsb(input int unsigned dw, input int unsigned xs);
    return dw + xs;
  endfunction

  function automatic logic [FLIT_MAX_W-1:0] flit_pack(
    input logic [FLIT_MAX_W-1:0] payload,
    input logic [FLIT_MAX_W-1:0] dest_x,
    input logic [FLIT_MAX_W-1:0] dest_y,
    input int unsigned           dw,
    input int unsigned           xs
  );
    return (dest_y << flit_y_lsb(dw, xs)) | (dest_x << flit_x_lsb(dw)) | payload;
  endfunction

endpackage

// File: rtl/noc_pe_interface_if.sv
// PE-side and router-side handshakes of the NoC PE interface.
// The slave modport is the interface block itself; master is its environment.
interface noc_pe_interface_if #(
  parameter int unsigned data_width  = 256,
  parameter int unsigned x_size      = 2,
  parameter int unsigned y_size      = 2,
  parameter int unsigned total_width = x_size + y_size + data_width
);
  logic                   s_valid;
  logic                   s_ready;
  logic [data_width-1:0]  s_data;
  logic [x_size-1:0]      s_dest_x;
  logic [y_size-1:0]      s_dest_y;
  logic                   o_valid_noc;
  logic                   i_ready_noc;
  logic [total_width-1:0] o_data_noc;
  logic                   i_valid_noc;
  logic [total_width-1:0] i_data_noc;
  logic                   m_valid;
  logic                   m_ready;
  logic [data_width-1:0]  m_data;

  modport slave (
    input  s_valid, s_data, s_dest_x, s_dest_y, i_ready_noc, i_valid_noc, i_data_noc, m_ready,
    output s_ready, o_valid_noc, o_data_noc, m_valid, m_data
  );

  modport master (
    output s_valid, s_data, s_dest_x, s_dest_y, i_ready_noc, i_valid_noc, i_data_noc, m_ready,
    input  s_ready, o_valid_noc, o_data_noc, m_valid, m_data
  );
endinterface

// File: rtl/noc_pe_interface_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; the caller only pushes when there is room
// (or when a same-cycle pop frees it) and only pops when not empty.
module noc_sync_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [width-1:0] mem_r [DEPTH];

  // Pointer update; reset empties the FIFO without touching storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (push) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

  assign dout  = mem_r[rd_ptr_r[AW-1:0]];
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

endmodule

// File: rtl/noc_pe_interface.sv
// PE <-> router adapter: packs PE beats into flits through a TX FIFO and buffers
// received payloads in an RX FIFO, counting overflow drops and flagging misroutes.
module noc_pe_interface
  import noc_pe_interface_pkg::*;
#(
  parameter int unsigned X           = 4,
  parameter int unsigned Y           = 4,
  parameter int unsigned x_coord     = 0,
  parameter int unsigned y_coord     = 0,
  parameter int unsigned data_width  = 256,
  parameter int unsigned x_size      = 2,
  parameter int unsigned y_size      = 2,
  parameter int unsigned total_width = x_size + y_size + data_width,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                clk,
  input  logic                rstn,
  noc_pe_interface_if.slave   bus,
  output logic [15:0]         drop_cnt,
  output logic                overflow,
  output logic                misroute
);
  localparam int unsigned X_LSB = flit_x_lsb(data_width);
  localparam int unsigned Y_LSB = flit_y_lsb(data_width, x_size);

  logic                   tx_full_s;
  logic                   tx_empty_s;
  logic                   tx_push_s;
  logic                   tx_pop_s;
  logic [total_width-1:0] tx_din_s;

  // No bypass: a full TX FIFO refuses the beat even if the router drains it this cycle.
  assign tx_push_s = bus.s_valid && !tx_full_s;
  assign tx_pop_s  = !tx_empty_s && bus.i_ready_noc;
  assign tx_din_s  = total_width'(flit_pack(FLIT_MAX_W'(bus.s_data), FLIT_MAX_W'(bus.s_dest_x),
                                            FLIT_MAX_W'(bus.s_dest_y), data_width, x_size));

  noc_sync_fifo #(.width(total_width), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (tx_push_s),
    .pop   (tx_pop_s),
    .din   (tx_din_s),
    .dout  (bus.o_data_noc),
    .full  (tx_full_s),
    .empty (tx_empty_s)
  );

  assign bus.s_ready     = !tx_full_s;
  assign bus.o_valid_noc = !tx_empty_s;

  logic                  rx_full_s;
  logic                  rx_empty_s;
  logic                  rx_push_s;
  logic                  rx_pop_s;
  logic                  rx_drop_s;
  logic                  misroute_hit_s;
  logic [x_size-1:0]     rx_dx_s;
  logic [y_size-1:0]     rx_dy_s;
  logic [15:0]           drop_cnt_r;
  rx_err_t               err_r;

  assign rx_dx_s   = bus.i_data_noc[X_LSB +: x_size];
  assign rx_dy_s   = bus.i_data_noc[Y_LSB +: y_size];
  // The router cannot be stalled, so a full RX FIFO only takes the flit if a pop frees a slot.
  assign rx_pop_s  = !rx_empty_s && bus.m_ready;
  assign rx_push_s = bus.i_valid_noc && (!rx_full_s || rx_pop_s);
  assign rx_drop_s = bus.i_valid_noc && rx_full_s && !rx_pop_s;
  // Destinations outside the mesh can never match this node and are flagged as well.
  assign misroute_hit_s = (32'(rx_dx_s) != x_coord) || (32'(rx_dy_s) != y_coord) ||
                          (32'(rx_dx_s) >= X)       || (32'(rx_dy_s) >= Y);

  noc_sync_fifo #(.width(data_width), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (rx_push_s),
    .pop   (rx_pop_s),
    .din   (bus.i_data_noc[data_width-1:0]),
    .dout  (bus.m_data),
    .full  (rx_full_s),
    .empty (rx_empty_s)
  );

  assign bus.m_valid = !rx_empty_s;

  // Saturating drop counter and sticky error flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt_r <= 16'd0;
      err_r      <= '{overflow: 1'b0, misroute: 1'b0};
    end else begin
      if (rx_drop_s && (drop_cnt_r != 16'hFFFF)) drop_cnt_r <= drop_cnt_r + 16'd1;
      if (rx_drop_s) err_r.overflow <= 1'b1;
      if (bus.i_valid_noc && misroute_hit_s) err_r.misroute <= 1'b1;
    end
  end

  assign drop_cnt = drop_cnt_r;
  assign overflow = err_r.overflow;
  assign misroute = err_r.misroute;

endmodule

// File: doc/noc_pe_interface.md
NOC_PE_INTERFACE -- requirements
Module: noc_pe_interface

Interface
REQ-001 SHALL have parameter X, default 4, mesh columns.
REQ-002 SHALL have parameter Y, default 4, mesh rows.
REQ-003 SHALL have parameter x_coord, default 0, this node's column.
REQ-004 SHALL have parameter y_coord, default 0, this node's row.
REQ-005 SHALL have parameter data_width, default 256, payload bits.
REQ-006 SHALL have parameter x_size, default 2, dest-x field bits.
REQ-007 SHALL have parameter y_size, default 2, dest-y field bits.
REQ-008 SHALL have parameter total_width, default x_size+y_size+data_width, NoC flit bits.
REQ-009 SHALL have parameter DEPTH, default 4, entries per FIFO; power of two, >=2.
REQ-010 clk  in  1  single clock; all logic rising-edge.
REQ-011 rstn  in  1  asynchronous, active-low reset.
REQ-012 s_valid / s_ready  in / out  1 / 1  PE transmit handshake.
REQ-013 s_data  in  data_width  PE transmit payload.
REQ-014 s_dest_x / s_dest_y  in  x_size / y_size  destination coordinates.
REQ-015 o_valid_noc / i_ready_noc  out / in  1 / 1  flit handshake toward the router's PE input.
REQ-016 o_data_noc  out  total_width  flit toward the router.
REQ-017 i_valid_noc  in  1  flit from the router's PE output; no back-pressure exists.
REQ-018 i_data_noc  in  total_width  flit from the router.
REQ-019 m_valid / m_ready  out / in  1 / 1  PE receive handshake.
REQ-020 m_data  out  data_width  received payload.
REQ-021 drop_cnt  out  16  count of flits dropped on RX overflow.
REQ-022 overflow / misroute  out  1 / 1  sticky error flags.

Function
REQ-023 Flit format SHALL be {dest_y, dest_x, payload}: payload in bits [data_width-1:0], dest_x above it, dest_y in the MSBs.
REQ-024 TX path SHALL be a DEPTH-entry FIFO; push on s_valid&&s_ready, pop on o_valid_noc&&i_ready_noc.
REQ-025 s_ready SHALL equal !tx_full; no bypass, so a full FIFO refuses a push even when a pop occurs that cycle.
REQ-026 o_valid_noc SHALL equal !tx_empty and o_data_noc SHALL be the FIFO head; latency from accepted s beat to o_valid_noc is 1 cycle.
REQ-027 o_data_noc SHALL stay stable while o_valid_noc=1 and i_ready_noc=0.
REQ-028 RX path SHALL be a DEPTH-entry FIFO storing payload only; push on i_valid_noc, pop on m_valid&&m_ready.
REQ-029 m_valid SHALL equal !rx_empty and m_data SHALL be the head; latency from i_valid_noc to m_valid is 1 cycle.
REQ-030 RX full with a same-cycle pop SHALL accept the incoming flit.
REQ-031 RX full without a pop SHALL drop the flit, set overflow, and increment drop_cnt, saturating at 16'hFFFF.
REQ-032 An RX flit whose dest field differs from {y_coord, x_coord} SHALL set misroute and still be stored.
REQ-033 FIFO pointers SHALL be log2(DEPTH) bits plus one wrap bit; full/empty are derived from wrap-bit compare, and pointers wrap modulo DEPTH.
REQ-034 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the occupancy unchanged.

Reset
REQ-035 While rstn=0, all pointers, drop_cnt, overflow and misroute SHALL be 0.
REQ-036 Reset state SHALL be s_ready=1, o_valid_noc=0, m_valid=0.
REQ-037 Reset asserted mid-transfer SHALL discard all buffered flits; FIFO storage arrays need no reset.

Structure
REQ-038 Flit field offsets and a flit-pack helper SHALL live in the shared NoC package used by the router.
REQ-039 One sub-module, noc_sync_fifo (parameters width and DEPTH, exposing full/empty), SHALL be instantiated twice.

Verification
REQ-040 Reset, then a PE beat payload=0xA5, dest=(2,1) with i_ready_noc=1 -> next cycle o_valid_noc=1, o_data_noc={2'd1, 2'd2, 0xA5}.
REQ-041 i_ready_noc=0 and 5 PE beats offered -> 4 accepted, s_ready=0 on the 5th; release -> 4 flits emerge in order with data unchanged throughout the stall.
REQ-042 m_ready=0 and 6 flits injected -> 4 stored, drop_cnt=2, overflow=1; drain -> first 4 payloads out in order.
REQ-043 RX full, flit arrives with m_ready=1 in the same cycle -> no drop, occupancy stays 4.
REQ-044 Node (1,1) receives a flit addressed to (3,0) -> misroute=1 and the payload is delivered.
REQ-045 rstn pulsed low with both FIFOs holding 3 entries -> o_valid_noc=0, m_valid=0, drop_cnt=0 immediately, without waiting for a clock edge.
